plat_scan_arbiter: RTL and testbench

Shares the platform-descriptor buses of the block generator between two requesters: the physics collision unit and the VGA platform renderer. The granted requester receives a race-free snapshot of the current block's platforms, streamed one descriptor per beat with valid/ready flow control. Sits between the block generator and the physics/render consumers, downstream of `block_switch`.

---
 rtl/plat_scan_arbiter.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_plat_scan_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plat_scan_arbiter.sv
// plat_scan_arbiter
// Shares the block generator's platform-descriptor buses between the physics
// collision unit and the VGA platform renderer. The granted requester gets a
// snapshot of the current block's platforms, streamed one descriptor per beat
// under valid/ready flow control.
//
// Build option: define PLAT_SCAN_RR_EN for round-robin arbitration between
// the two requesters. Left undefined, physics has fixed priority over VGA and
// no last-owner register is built.

module plat_scan_arbiter #(
    parameter int PLATFORM_NUM_PER_BLOCK = 10,
    parameter int VALID_PLAT_NUM         = 7,
    parameter int PHY_WIDTH              = 14,
    parameter int BLOCK_LEN_WIDTH        = 4,
    parameter int IDX_WIDTH              = 4
) (
    input  logic                                          sys_clk,
    input  logic                                          sys_rst,
    input  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]   plat_relative_x,
    input  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]   plat_relative_y,
    input  logic [PLATFORM_NUM_PER_BLOCK*BLOCK_LEN_WIDTH-1:0] plat_len,
    input  logic                                          block_switch,
    input  logic                                          phy_req,
    input  logic                                          vga_req,
    input  logic                                          scan_ready,
    output logic                                          phy_gnt,
    output logic                                          vga_gnt,
    output logic                                          scan_valid,
    output logic                                          scan_last,
    output logic [IDX_WIDTH-1:0]                          scan_idx,
    output logic [PHY_WIDTH-1:0]                          scan_x,
    output logic [PHY_WIDTH-1:0]                          scan_y,
    output logic [BLOCK_LEN_WIDTH-1:0]                    scan_len,
    output logic                                          scan_done,
    output logic                                          scan_stale
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Owner encoding
    localparam logic OWNER_PHY = 1'b0;
    localparam logic OWNER_VGA = 1'b1;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(VALID_PLAT_NUM - 1);
    localparam logic [IDX_WIDTH-1:0] ONE_IDX  = IDX_WIDTH'(1);

    // Unpacked views of the live descriptor buses
    logic [PHY_WIDTH-1:0]       busX   [PLATFORM_NUM_PER_BLOCK];
    logic [PHY_WIDTH-1:0]       busY   [PLATFORM_NUM_PER_BLOCK];
    logic [BLOCK_LEN_WIDTH-1:0] busLen [PLATFORM_NUM_PER_BLOCK];

    // Snapshot taken when a scan starts; never touched mid-scan
    logic [PHY_WIDTH-1:0]       snapX_q   [PLATFORM_NUM_PER_BLOCK];
    logic [PHY_WIDTH-1:0]       snapY_q   [PLATFORM_NUM_PER_BLOCK];
    logic [BLOCK_LEN_WIDTH-1:0] snapLen_q [PLATFORM_NUM_PER_BLOCK];

    // Control state
    logic [1:0]           state_q,  state_d;
    logic                 owner_q,  owner_d;
    logic [IDX_WIDTH-1:0] idx_q,    idx_d;
    logic                 stale_q,  stale_d;
    logic                 loadSnap;

    // Registered outputs
    logic                       phyGnt_q,    phyGnt_d;
    logic                       vgaGnt_q,    vgaGnt_d;
    logic                       valid_q,     valid_d;
    logic                       last_q,      last_d;
    logic [IDX_WIDTH-1:0]       scanIdx_q,   scanIdx_d;
    logic [PHY_WIDTH-1:0]       scanX_q,     scanX_d;
    logic [PHY_WIDTH-1:0]       scanY_q,     scanY_d;
    logic [BLOCK_LEN_WIDTH-1:0] scanLen_q,   scanLen_d;
    logic                       done_q,      done_d;
    logic                       staleOut_q,  staleOut_d;

    // Helpers
    logic                 winner;
    logic                 ownerReq;
    logic [IDX_WIDTH-1:0] nextIdx;

    // Slice the flattened buses into per-slot descriptors
    always_comb begin
        for (int i = 0; i < PLATFORM_NUM_PER_BLOCK; i++) begin
            busX[i]   = plat_relative_x[i*PHY_WIDTH +: PHY_WIDTH];
            busY[i]   = plat_relative_y[i*PHY_WIDTH +: PHY_WIDTH];
            busLen[i] = plat_len[i*BLOCK_LEN_WIDTH +: BLOCK_LEN_WIDTH];
        end
    end

`ifdef PLAT_SCAN_RR_EN
    logic lastOwner_q;

    // Remember who was served last so that contention alternates
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            lastOwner_q <= OWNER_VGA;
        end else if (state_q == ST_IDLE && (phy_req || vga_req)) begin
            lastOwner_q <= winner;
        end
    end

    // Round-robin pick: under contention the one not served last wins
    always_comb begin
        winner = OWNER_PHY;
        if (phy_req && vga_req) begin
            winner = ~lastOwner_q;
        end else if (!phy_req) begin
            winner = OWNER_VGA;
        end
    end
`else
    // Fixed-priority pick: physics always beats VGA
    always_comb begin
        winner = phy_req ? OWNER_PHY : OWNER_VGA;
    end
`endif

    // The current owner's request line; dropping it aborts the scan
    always_comb begin
        ownerReq = (owner_q == OWNER_PHY) ? phy_req : vga_req;
        nextIdx  = idx_q + ONE_IDX;
    end

    // Next-state and next-output logic; every output is computed one cycle
    // ahead so it comes straight out of a flop
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        idx_d      = idx_q;
        stale_d    = stale_q;
        loadSnap   = 1'b0;
        phyGnt_d   = phyGnt_q;
        vgaGnt_d   = vgaGnt_q;
        valid_d    = 1'b0;
        last_d     = 1'b0;
        scanIdx_d  = '0;
        scanX_d    = '0;
        scanY_d    = '0;
        scanLen_d  = '0;
        done_d     = 1'b0;
        staleOut_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (phy_req || vga_req) begin
                    state_d  = ST_LOAD;
                    owner_d  = winner;
                    phyGnt_d = (winner == OWNER_PHY);
                    vgaGnt_d = (winner == OWNER_VGA);
                end
            end

            ST_LOAD: begin
                if (!ownerReq) begin
                    state_d  = ST_IDLE;
                    phyGnt_d = 1'b0;
                    vgaGnt_d = 1'b0;
                end else begin
                    loadSnap  = 1'b1;
                    idx_d     = '0;
                    stale_d   = block_switch;
                    state_d   = ST_SCAN;
                    valid_d   = 1'b1;
                    last_d    = (LAST_IDX == '0);
                    scanIdx_d = '0;
                    scanX_d   = busX[0];
                    scanY_d   = busY[0];
                    scanLen_d = busLen[0];
                end
            end

            ST_SCAN: begin
                if (!ownerReq) begin
                    state_d  = ST_IDLE;
                    phyGnt_d = 1'b0;
                    vgaGnt_d = 1'b0;
                end else begin
                    stale_d = stale_q | block_switch;
                    if (scan_ready && valid_q) begin
                        if (idx_q == LAST_IDX) begin
                            state_d    = ST_DONE;
                            phyGnt_d   = 1'b0;
                            vgaGnt_d   = 1'b0;
                            done_d     = 1'b1;
                            staleOut_d = stale_q | block_switch;
                        end else begin
                            idx_d     = nextIdx;
                            valid_d   = 1'b1;
                            last_d    = (nextIdx == LAST_IDX);
                            scanIdx_d = nextIdx;
                            scanX_d   = snapX_q[nextIdx];
                            scanY_d   = snapY_q[nextIdx];
                            scanLen_d = snapLen_q[nextIdx];
                        end
                    end else begin
                        valid_d   = 1'b1;
                        last_d    = (idx_q == LAST_IDX);
                        scanIdx_d = idx_q;
                        scanX_d   = snapX_q[idx_q];
                        scanY_d   = snapY_q[idx_q];
                        scanLen_d = snapLen_q[idx_q];
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d  = ST_IDLE;
                phyGnt_d = 1'b0;
                vgaGnt_d = 1'b0;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWNER_PHY;
            idx_q      <= '0;
            stale_q    <= 1'b0;
            phyGnt_q   <= 1'b0;
            vgaGnt_q   <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            scanIdx_q  <= '0;
            scanX_q    <= '0;
            scanY_q    <= '0;
            scanLen_q  <= '0;
            done_q     <= 1'b0;
            staleOut_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            idx_q      <= idx_d;
            stale_q    <= stale_d;
            phyGnt_q   <= phyGnt_d;
            vgaGnt_q   <= vgaGnt_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            scanIdx_q  <= scanIdx_d;
            scanX_q    <= scanX_d;
            scanY_q    <= scanY_d;
            scanLen_q  <= scanLen_d;
            done_q     <= done_d;
            staleOut_q <= staleOut_d;
        end
    end

    // Snapshot capture at the start of a scan
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < PLATFORM_NUM_PER_BLOCK; i++) begin
                snapX_q[i]   <= '0;
                snapY_q[i]   <= '0;
                snapLen_q[i] <= '0;
            end
        end else if (loadSnap) begin
            for (int i = 0; i < PLATFORM_NUM_PER_BLOCK; i++) begin
                snapX_q[i]   <= busX[i];
                snapY_q[i]   <= busY[i];
                snapLen_q[i] <= busLen[i];
            end
        end
    end

    assign phy_gnt    = phyGnt_q;
    assign vga_gnt    = vgaGnt_q;
    assign scan_valid = valid_q;
    assign scan_last  = last_q;
    assign scan_idx   = scanIdx_q;
    assign scan_x     = scanX_q;
    assign scan_y     = scanY_q;
    assign scan_len   = scanLen_q;
    assign scan_done  = done_q;
    assign scan_stale = staleOut_q;

endmodule

// File: tb/tb_plat_scan_arbiter.sv
// tb_plat_scan_arbiter
// Directed sequence with randomized descriptor contents and flow control,
// compared against a transaction-level model: each scan must reproduce the
// bus contents present when the grant appeared, in slot order, regardless of
// ready stalls or later bus changes. Honours PLAT_SCAN_RR_EN like the design.

module tb_plat_scan_arbiter;

    localparam int N     = 10;
    localparam int VALID = 7;
    localparam int W     = 14;
    localparam int L     = 4;
    localparam int IW    = 4;

    logic              sys_clk;
    logic              sys_rst;
    logic [N*W-1:0]    plat_relative_x;
    logic [N*W-1:0]    plat_relative_y;
    logic [N*L-1:0]    plat_len;
    logic              block_switch;
    logic              phy_req;
    logic              vga_req;
    logic              scan_ready;
    logic              phy_gnt;
    logic              vga_gnt;
    logic              scan_valid;
    logic              scan_last;
    logic [IW-1:0]     scan_idx;
    logic [W-1:0]      scan_x;
    logic [W-1:0]      scan_y;
    logic [L-1:0]      scan_len;
    logic              scan_done;
    logic              scan_stale;

    // Bench-side view of the block generator's buses
    logic [W-1:0] bx [N];
    logic [W-1:0] by [N];
    logic [L-1:0] bl [N];

    // Expected snapshot of the scan in progress
    logic [W-1:0] sx [N];
    logic [W-1:0] sy [N];
    logic [L-1:0] sl [N];

    logic lastOwner;
    int   checks;
    int   errors;

    plat_scan_arbiter #(
        .PLATFORM_NUM_PER_BLOCK(N),
        .VALID_PLAT_NUM(VALID),
        .PHY_WIDTH(W),
        .BLOCK_LEN_WIDTH(L),
        .IDX_WIDTH(IW)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .plat_relative_x(plat_relative_x),
        .plat_relative_y(plat_relative_y),
        .plat_len(plat_len),
        .block_switch(block_switch),
        .phy_req(phy_req),
        .vga_req(vga_req),
        .scan_ready(scan_ready),
        .phy_gnt(phy_gnt),
        .vga_gnt(vga_gnt),
        .scan_valid(scan_valid),
        .scan_last(scan_last),
        .scan_idx(scan_idx),
        .scan_x(scan_x),
        .scan_y(scan_y),
        .scan_len(scan_len),
        .scan_done(scan_done),
        .scan_stale(scan_stale)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Pack the per-slot arrays onto the flattened buses
    always_comb begin
        plat_relative_x = '0;
        plat_relative_y = '0;
        plat_len        = '0;
        for (int i = 0; i < N; i++) begin
            plat_relative_x[i*W +: W] = bx[i];
            plat_relative_y[i*W +: W] = by[i];
            plat_len[i*L +: L]        = bl[i];
        end
    end

    // Safety net in case the sequence itself wedges
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // New random block contents on the buses
    task automatic applyStimulus();
        for (int i = 0; i < N; i++) begin
            bx[i] = W'($urandom);
            by[i] = W'($urandom);
            bl[i] = L'($urandom);
        end
    endtask

    // Arbitration rule: 0 = physics, 1 = VGA
    function automatic logic predictWinner(input logic p, input logic v);
        if (p && v) begin
`ifdef PLAT_SCAN_RR_EN
            return ~lastOwner;
`else
            return 1'b0;
`endif
        end
        return p ? 1'b0 : 1'b1;
    endfunction

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_phy_gnt"}, phy_gnt, 0);
        checkOutput({tag, "_vga_gnt"}, vga_gnt, 0);
        checkOutput({tag, "_valid"}, scan_valid, 0);
        checkOutput({tag, "_fields"}, {scan_last, scan_idx, scan_x, scan_y, scan_len}, 0);
        checkOutput({tag, "_done"}, {scan_done, scan_stale}, 0);
    endtask

    // Called in an IDLE cycle with requests set; ends on the first beat cycle
    task automatic expectGrant();
        logic w;
        w = predictWinner(phy_req, vga_req);
        tick();
        checkOutput("grant_phy", phy_gnt, {63'd0, w == 1'b0});
        checkOutput("grant_vga", vga_gnt, {63'd0, w == 1'b1});
        checkOutput("load_valid", scan_valid, 0);
        lastOwner = w;
        for (int i = 0; i < N; i++) begin
            sx[i] = bx[i];
            sy[i] = by[i];
            sl[i] = bl[i];
        end
        tick();
    endtask

    // Consume beats; mode 0 ready high, 1 ready 1-in-3, 2 random ready.
    // Returns early (without ticking) when beat abortBeat is on the bus.
    task automatic runScan(input int mode, input int bsBeat, input logic expStale,
                           input int abortBeat);
        int expIdx;
        int cyc;
        bit bsSent;
        logic rdy;
        expIdx = 0;
        cyc    = 0;
        bsSent = 0;
        while (expIdx < VALID && cyc < 200) begin
            checkOutput("beat_valid", scan_valid, 1);
            checkOutput("beat_idx", scan_idx, expIdx);
            checkOutput("beat_x", scan_x, sx[expIdx]);
            checkOutput("beat_y", scan_y, sy[expIdx]);
            checkOutput("beat_len", scan_len, sl[expIdx]);
            checkOutput("beat_last", scan_last, {63'd0, expIdx == VALID - 1});
            checkOutput("beat_done", scan_done, 0);
            checkOutput("beat_gnt", phy_gnt ^ vga_gnt, 1);
            if (expIdx == abortBeat) return;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 2);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            scan_ready = rdy;
            if (expIdx == bsBeat && !bsSent) begin
                block_switch = 1'b1;
                bsSent = 1;
                applyStimulus();
            end else begin
                block_switch = 1'b0;
            end
            tick();
            cyc++;
            if (rdy) expIdx++;
        end
        block_switch = 1'b0;
        scan_ready   = 1'b1;
        checkOutput("scan_budget", expIdx, VALID);
        checkOutput("done_pulse", scan_done, 1);
        checkOutput("done_stale", scan_stale, {63'd0, expStale});
        checkOutput("done_valid", scan_valid, 0);
        checkOutput("done_gnt", {phy_gnt, vga_gnt}, 0);
        checkOutput("done_fields", {scan_last, scan_idx, scan_x, scan_y, scan_len}, 0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        lastOwner    = 1'b1;
        sys_rst      = 1'b1;
        phy_req      = 1'b1;
        vga_req      = 1'b0;
        scan_ready   = 1'b1;
        block_switch = 1'b0;
        applyStimulus();
        bx[0] = W'(400);
        by[0] = W'(60);
        bl[0] = L'(8);

        // Reset held with a pending physics request
        for (int i = 0; i < 3; i++) begin
            tick();
            checkQuiet("reset");
        end

        // Release: grant next cycle, full scan with ready high
        sys_rst = 1'b0;
        expectGrant();
        checkOutput("first_x_400", scan_x, 400);
        runScan(0, -1, 1'b0, -1);
        phy_req = 1'b0;
        tick();
        checkQuiet("idle1");

        // Contention, then keep both requests up for a back-to-back scan
        phy_req = 1'b1;
        vga_req = 1'b1;
        applyStimulus();
        expectGrant();
        runScan(1, -1, 1'b0, -1);
        tick();
        checkQuiet("b2b_idle");
        expectGrant();
        runScan(2, 3, 1'b1, -1);
        phy_req = 1'b0;
        vga_req = 1'b0;
        tick();
        checkQuiet("idle2");

        // Abort at beat 2 with VGA waiting
        phy_req = 1'b1;
        applyStimulus();
        expectGrant();
        vga_req = 1'b1;
        runScan(0, -1, 1'b0, 2);
        phy_req = 1'b0;
        tick();
        checkQuiet("abort");
        expectGrant();
        runScan(0, -1, 1'b0, -1);
        vga_req = 1'b0;
        tick();
        checkQuiet("idle3");

        // Randomized rounds
        for (int r = 0; r < 6; r++) begin
            int code;
            int bs;
            code = int'($urandom_range(1, 3));
            bs   = int'($urandom_range(0, 7));
            phy_req = code[0];
            vga_req = code[1];
            applyStimulus();
            expectGrant();
            if (bs == 7) runScan(2, -1, 1'b0, -1);
            else         runScan(2, bs, 1'b1, -1);
            phy_req = 1'b0;
            vga_req = 1'b0;
            tick();
            checkQuiet("rand_idle");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
